// File: rtl/mac_acc32.sv
// Accumulates a stream of unsigned 32-bit products into one ACC_W-bit sum per block.
// Latency: the result is presented one cycle after the beat carrying in_last.
// Backpressure: the result is held until out_ready; no beats are taken while it is held.
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   in_valid/in_ready          product beat handshake (prod, in_last)
//   out_valid/out_ready        result handshake (out_acc, out_cnt, out_ovf)
// Optional feature macro: MAC_ACC_SAT_EN. When it is defined, the accumulator
// clamps to all-ones on carry-out. When it is not defined, the accumulator wraps.
module mac_acc32 #(
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [15:0]      out_cnt,
  output logic             out_ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // One extra bit on the sum exposes the carry-out of the ACC_W-bit addition.
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] acc_add;

  assign sum_w = {1'b0, acc_q} + {{(ACC_W - 31){1'b0}}, prod};

`ifdef MAC_ACC_SAT_EN
  // Once the accumulator is clamped, any further nonzero beat carries out again.
  // A zero beat leaves the value unchanged. Either way it stays at all-ones.
  assign acc_add = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
  assign acc_add = sum_w[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_add;
          ovf_d = ovf_q | sum_w[ACC_W];
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // The state register already reads ACCUM during reset.
  // in_ready is therefore also gated by rst_n, so no beat appears to be taken while reset is held.
  assign in_ready  = rst_n && (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_acc   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_acc32.sv
// Bench for mac_acc32 at ACC_W = 33, so that overflow is reachable in a few beats.
// Expected results are queued when the last beat is driven. They are popped when out_valid shows.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mac_acc32;

  localparam int ACC_W = 33;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [15:0]      cnt;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      prod = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_acc;
  logic [15:0]      out_cnt;
  logic             out_ovf;

  int   checks = 0;
  int   passed = 0;
  res_t exp_q[$];
  res_t e;

  mac_acc32 #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Presents one beat for a single cycle; called on a falling edge while in ACCUM.
  task automatic drive_beat(input logic [31:0] v, input logic last);
    in_valid = 1'b1;
    prod     = v;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    prod     = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else passed++;
    checks++; if ({out_acc, out_cnt, out_ovf} !== '0) $display("FAIL rst_outputs got %h/%h/%b exp 0", out_acc, out_cnt, out_ovf); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    exp_q.push_back('{acc: 33'd15, cnt: 16'd3, ovf: 1'b0});
    drive_beat(32'd3, 1'b0);
    drive_beat(32'd5, 1'b0);
    drive_beat(32'd7, 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency out_valid got %b exp 1", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready got %b exp 0", in_ready); else passed++;
    e = exp_q.pop_front();
    checks++; if ({out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL basic_result got %h/%0d/%b exp %h/%0d/%b", out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_return got ov=%b ir=%b exp 0/1", out_valid, in_ready); else passed++;
    checks++; if ({out_acc, out_cnt, out_ovf} !== '0) $display("FAIL basic_clear got %h/%h/%b exp 0", out_acc, out_cnt, out_ovf); else passed++;
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    exp_q.push_back('{acc: 33'h0FFFE0001, cnt: 16'd1, ovf: 1'b0});
    drive_beat(32'hFFFE0001, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold_flags cyc %0d got ov=%b ir=%b exp 1/0", i, out_valid, in_ready); else passed++;
      checks++; if ({out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
        $display("FAIL hold_result cyc %0d got %h/%0d/%b exp %h/%0d/%b", i, out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
      in_valid = 1'b1; prod = 32'h1234; in_last = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; prod = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_acc !== '0) $display("FAIL hold_release got ov=%b acc=%h exp 0/0", out_valid, out_acc); else passed++;
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
`ifdef MAC_ACC_SAT_EN
    exp_q.push_back('{acc: 33'h1FFFFFFFF, cnt: 16'd3, ovf: 1'b1});
`else
    exp_q.push_back('{acc: 33'h0FFFFFFFD, cnt: 16'd3, ovf: 1'b1});
`endif
    drive_beat(32'hFFFFFFFF, 1'b0);
    drive_beat(32'hFFFFFFFF, 1'b0);
    checks++; if (out_ovf !== 1'b0 || out_acc !== 33'h1FFFFFFFE) $display("FAIL ovf_pre got %h/%b exp 1fffffffe/0", out_acc, out_ovf); else passed++;
    drive_beat(32'hFFFFFFFF, 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL ovf_valid got %b exp 1", out_valid); else passed++;
    e = exp_q.pop_front();
    checks++; if ({out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL ovf_result got %h/%0d/%b exp %h/%0d/%b", out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_ovf !== 1'b0) $display("FAIL ovf_clear got %b exp 0", out_ovf); else passed++;
  endtask

  task automatic test_toggle;
    out_ready = 1'b0;
    exp_q.push_back('{acc: 33'd4, cnt: 16'd4, ovf: 1'b0});
    for (int i = 0; i < 4; i++) begin
      drive_beat(32'd1, (i == 3));
      if (i < 3) @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) $display("FAIL toggle_valid got %b exp 1", out_valid); else passed++;
    e = exp_q.pop_front();
    checks++; if ({out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL toggle_result got %h/%0d/%b exp %h/%0d/%b", out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    in_valid = 1'b1; prod = 32'd100; in_last = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; prod = '0; in_last = 1'b0;
    checks++; if (out_acc !== e.acc || out_cnt !== e.cnt) $display("FAIL toggle_hold_ignore got %h/%0d exp %h/%0d", out_acc, out_cnt, e.acc, e.cnt); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_cnt !== 16'd0) $display("FAIL toggle_release got ov=%b cnt=%0d exp 0/0", out_valid, out_cnt); else passed++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    drive_beat(32'd10, 1'b0);
    drive_beat(32'd10, 1'b0);
    checks++; if (out_acc !== 33'd20 || out_cnt !== 16'd2) $display("FAIL rstmid_partial got %h/%0d exp 14/2", out_acc, out_cnt); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_acc, out_cnt, out_ovf} !== '0) $display("FAIL rstmid_outputs got %h/%h/%b exp 0", out_acc, out_cnt, out_ovf); else passed++;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL rstmid_flags got ir=%b ov=%b exp 0/0", in_ready, out_valid); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back('{acc: 33'd3, cnt: 16'd2, ovf: 1'b0});
    drive_beat(32'd1, 1'b0);
    drive_beat(32'd2, 1'b1);
    checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid got %b exp 1", out_valid); else passed++;
    e = exp_q.pop_front();
    checks++; if ({out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL rstmid_result got %h/%0d/%b exp %h/%0d/%b", out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    exp_q.push_back('{acc: 33'd4, cnt: 16'd2, ovf: 1'b0});
    drive_beat(32'd2, 1'b0);
    drive_beat(32'd2, 1'b1);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL b2b_first got ov=%b %h/%0d/%b exp 1 %h/%0d/%b", out_valid, out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL b2b_bubble got %b exp 0", in_ready); else passed++;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_reready got %b exp 1", in_ready); else passed++;
    exp_q.push_back('{acc: 33'd9, cnt: 16'd1, ovf: 1'b0});
    drive_beat(32'd9, 1'b1);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL b2b_second got ov=%b %h/%0d/%b exp 1 %h/%0d/%b", out_valid, out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    @(negedge clk);
  endtask

  task automatic test_cnt_sat;
    out_ready = 1'b1;
    exp_q.push_back('{acc: 33'd65537, cnt: 16'hFFFF, ovf: 1'b0});
    in_valid = 1'b1; prod = 32'd1; in_last = 1'b0;
    repeat (65536) @(negedge clk);
    drive_beat(32'd1, 1'b1);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_acc, out_cnt, out_ovf} !== {e.acc, e.cnt, e.ovf})
      $display("FAIL cntsat_result got ov=%b %h/%h/%b exp 1 %h/%h/%b", out_valid, out_acc, out_cnt, out_ovf, e.acc, e.cnt, e.ovf); else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_toggle();
    test_reset_mid();
    test_back_to_back();
    test_cnt_sat();
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty got %0d exp 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mac_acc32.md
MAC_ACC32 -- requirements
Module: mac_acc32

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator width in bits (legal range 33..64).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  product beat present.
REQ-005 SHALL have port in_ready  output  1  block can accept a beat.
REQ-006 SHALL have port prod  input  32  unsigned 16x16 product from the upstream multiplier.
REQ-007 SHALL have port in_last  input  1  beat is final product of the current block.
REQ-008 SHALL have port out_valid  output  1  result held on out_acc/out_cnt/out_ovf.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_acc  output  ACC_W  accumulated sum of the block.
REQ-011 SHALL have port out_cnt  output  16  number of beats in the block.
REQ-012 SHALL have port out_ovf  output  1  sticky: accumulator overflowed during the block.

Function
REQ-013 SHALL use one clock; reset is asynchronous and active-low.
REQ-014 SHALL define beat acceptance as in_valid && in_ready at a rising clk edge; out handshake as out_valid && out_ready.
REQ-015 SHALL implement states ACCUM and HOLD; ACCUM after reset.
REQ-016 SHALL drive in_ready = 1 in ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-017 SHALL, on accepted beat in ACCUM, update acc <= acc + zero-extended prod, cnt <= cnt + 1 (cnt saturates at 0xFFFF, no wrap).
REQ-018 SHALL set sticky ovf when the ACC_W-bit addition carries out; ovf stays set until block ends.
REQ-019 SHALL, on accepted beat with in_last = 1, perform the REQ-017 update and enter HOLD; out_valid asserts the next cycle (latency 1 from last beat).
REQ-020 SHALL hold out_acc, out_cnt, out_ovf stable while in HOLD and out_ready = 0.
REQ-021 SHALL, on out handshake in HOLD, clear acc, cnt, ovf to 0 and return to ACCUM; in_ready reasserts the following cycle (one bubble minimum between blocks).
REQ-022 SHALL ignore in_valid, prod, in_last while in HOLD.
REQ-023 SHALL treat a block of one beat (in_last on first beat) identically: out_acc = prod, out_cnt = 1.
REQ-024 SHALL treat in_valid = 0 cycles in ACCUM as no-ops (state unchanged).
REQ-025 SHALL drive out_acc = acc, out_cnt = cnt, out_ovf = ovf directly from registers (no combinational path from inputs to outputs except none; in_ready/out_valid decode from state only).

Reset
REQ-026 SHALL, on rst_n low, immediately force state ACCUM, acc = 0, cnt = 0, ovf = 0, out_valid = 0, in_ready = 1 after release.
REQ-027 SHALL discard any partial block or held result when reset asserts mid-operation; no output handshake occurs for it.
REQ-028 SHALL keep in_ready = 0 while rst_n is low.

Configuration
REQ-029 SHALL support macro MAC_ACC_SAT_EN.
REQ-030 SHALL, with MAC_ACC_SAT_EN defined, clamp acc to all-ones (2^ACC_W - 1) on carry-out and hold it there for remaining beats; ovf still sets.
REQ-031 SHALL, without MAC_ACC_SAT_EN, wrap acc modulo 2^ACC_W on carry-out; ovf sets.

Verification
REQ-032 SHALL cover: beats 3, 5, 7 (last on 7), out_ready = 1 -> out_valid one cycle after last, out_acc = 15, out_cnt = 3, out_ovf = 0.
REQ-033 SHALL cover: single beat 0xFFFE0001 with in_last -> out_acc = 0xFFFE0001, out_cnt = 1; held stable for 5 cycles of out_ready = 0, in_ready = 0 throughout.
REQ-034 SHALL cover: ACC_W = 33, beats 0xFFFFFFFF x3 -> without macro out_acc = 0x0FFFFFFFD, out_ovf = 1; with MAC_ACC_SAT_EN out_acc = 0x1FFFFFFFF, out_ovf = 1.
REQ-035 SHALL cover: in_valid toggled 1/0 over 4 beats of value 1, in_last on 4th -> out_cnt = 4, out_acc = 4; beats presented during HOLD ignored.
REQ-036 SHALL cover: reset asserted after 2 beats of 10 -> all outputs 0 immediately; next block 1, 2 (last) -> out_acc = 3, out_cnt = 2.
REQ-037 SHALL cover: two back-to-back blocks (2,2 last; 9 last) with out_ready = 1 -> results 4/2 then 9/1, ovf = 0 both, one bubble between.
